// File: rtl/pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipe_adder_pkg
// Shared constants, helpers and the stage record layout for pipe_adder.
//   PIPE_ADDER_WIDTH  : default operand/sum width
//   PIPE_ADDER_STAGES : default pipeline depth (one slice per stage)
//   slice_w()         : bits handled per stage
//   stage_t           : per-stage register record at the default width
// ---------------------------------------------------------------------------
package pipe_adder_pkg;

    localparam int PIPE_ADDER_WIDTH  = 16;
    localparam int PIPE_ADDER_STAGES = 4;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Register layout of one pipeline stage. pipe_adder declares the same
    // layout sized by its own WIDTH parameter, since a package typedef
    // cannot follow a module parameter.
    typedef struct packed {
        logic                        valid;
        logic                        carry;
        logic [PIPE_ADDER_WIDTH-1:0] psum;   // lower slices already summed
        logic [PIPE_ADDER_WIDTH-1:0] a_rem;  // operand A slices still to add
        logic [PIPE_ADDER_WIDTH-1:0] b_rem;  // operand B slices still to add
    } stage_t;

endpackage

// File: rtl/pipe_adder_if.sv
// ---------------------------------------------------------------------------
// pipe_adder_if
// Valid/ready operand and result channels of pipe_adder.
//   in_valid/in_ready/a/b/cin     : operand channel (producer -> adder)
//   out_valid/out_ready/sum/cout  : result channel  (adder -> consumer)
// Modports:
//   slave  : the adder side
//   master : the environment side, acting as both producer and consumer
// ---------------------------------------------------------------------------
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = PIPE_ADDER_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/pipe_adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Combinational SLICE-bit full adder used as one stage of pipe_adder.
//   a_s, b_s : operand slices
//   c_in     : carry from the previous slice
//   s        : sum slice
//   c_out    : carry to the next slice
// ---------------------------------------------------------------------------
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             c_in,
    output logic [SLICE-1:0] s,
    output logic             c_out
);

    assign {c_out, s} = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, c_in};

endmodule

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
// Pipelined unsigned adder: {cout, sum} = a + b + cin, split into STAGES
// slices with the carry rippling one slice per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : pipe_adder_if.slave (operand and result valid/ready channels)
// Optional build macro:
//   PIPE_ADDER_SAT_EN : on overflow sum saturates to all ones, cout stays 1
// ---------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = PIPE_ADDER_WIDTH,
    parameter int STAGES = PIPE_ADDER_STAGES
) (
    input  logic        clk,
    input  logic        rst,
    pipe_adder_if.slave bus
);

    localparam int SLICE = slice_w(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_check
        $fatal(1, "pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_rec_t;

    stage_rec_t       stage_q [STAGES];
    stage_rec_t       stage_d [STAGES];
    stage_rec_t       src     [STAGES];  // what each stage would load
    logic [SLICE-1:0] s_w     [STAGES];
    logic             c_w     [STAGES];
    logic             adv;

    // The whole pipe moves or holds as one; the output register is free
    // whenever it is empty or being consumed this cycle.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 0 takes the raw operands and cin; every later stage takes
    // the record its predecessor registered.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src[k]       = '0;
                src[k].valid = bus.in_valid;
                src[k].carry = bus.cin;
                src[k].a_rem = bus.a;
                src[k].b_rem = bus.b;
            end else begin
                src[k] = stage_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a_s   (src[k].a_rem[k*SLICE +: SLICE]),
            .b_s   (src[k].b_rem[k*SLICE +: SLICE]),
            .c_in  (src[k].carry),
            .s     (s_w[k]),
            .c_out (c_w[k])
        );
    end

    // NOTE: every output of a combinational block is given a value before
    // any condition (here: hold), so no path leaves it unassigned and no
    // latch is inferred.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (adv) begin
                stage_d[k]                         = src[k];
                stage_d[k].psum[k*SLICE +: SLICE]  = s_w[k];
                stage_d[k].carry                   = c_w[k];
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every stage samples its predecessor's pre-edge value, giving a true
    // shift rather than a fall-through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign bus.out_valid = stage_q[STAGES-1].valid;
    assign bus.cout      = stage_q[STAGES-1].carry;

`ifdef PIPE_ADDER_SAT_EN
    assign bus.sum = stage_q[STAGES-1].carry ? {WIDTH{1'b1}} : stage_q[STAGES-1].psum;
`else
    assign bus.sum = stage_q[STAGES-1].psum;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4). Stimulus pushes
// hand-computed results into a queue; a monitor pops and compares on every
// result transfer.
// ---------------------------------------------------------------------------
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus ();

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected sums are given as the wrapping result; the saturating build
    // replaces the sum with all ones whenever the carry-out is set.
    task automatic push_exp(input logic [W-1:0] s, input logic c);
        exp_t e;
        e.sum  = s;
        e.cout = c;
`ifdef PIPE_ADDER_SAT_EN
        if (c) e.sum = '1;
`endif
        sb.push_back(e);
    endtask

    // Presents one operand set and holds it until accepted (bounded).
    // Returns on the falling edge before the accepting rising edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push_exp(es, ec);
                return;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never rose for a=0x%0h b=0x%0h", a, b);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the presentation cycle of the last send to out_valid.
    task automatic measure_latency(input string name);
        int k;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            @(negedge clk);
            k++;
            if (bus.out_valid) break;
        end
        check(name, k, S);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check(name, sb.size(), 0);
    endtask

    // Scoreboard monitor: compares every accepted result in issue order.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_result: got sum=0x%0h cout=%0b, expected no result",
                         bus.sum, bus.cout);
            end else begin
                e = sb.pop_front();
                check("result_sum", bus.sum, e.sum);
                check("result_cout", bus.cout, e.cout);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] vec;
        int         cnt;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_sum", bus.sum, 0);
        check("reset_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Carry crossing a slice boundary, wrap-around, cin-driven ripple.
        send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        measure_latency("latency_00ff");
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        measure_latency("latency_ffff");
        send(16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1);
        measure_latency("latency_7fff_cin");
        drain("drain_directed");

        // Back-to-back issue: four results on four consecutive cycles.
        send(16'd1, 16'd1, 1'b0, 16'd2, 1'b0);
        send(16'd2, 16'd2, 1'b0, 16'd4, 1'b0);
        send(16'd3, 16'd3, 1'b0, 16'd6, 1'b0);
        send(16'd4, 16'd4, 1'b0, 16'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle();
            @(negedge clk);
            vec[i] = bus.out_valid;
        end
        check("b2b_valid_pattern", vec, 8'h0F);
        drain("drain_b2b");

        // Fill with the consumer stalled, hold three cycles, then release.
        bus.out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        send(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1);
        send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        @(posedge clk); #1;
        bus.a   = 16'h00FF;
        bus.b   = 16'h0F01;
        bus.cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_sum", bus.sum, 16'h3333);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", bus.in_ready, 1);
        if (bus.in_ready) push_exp(16'h1000, 1'b0);
        idle();
        drain("drain_stall");

        // Reset with three results in flight, one already at the output.
        bus.out_ready = 1'b0;
        send(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0);
        send(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0);
        send(16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0);
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_reset_out_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_sum", bus.sum, 0);
        check("midrst_cout", bus.cout, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("post_reset_no_stale", cnt, 0);
        send(16'h0ABC, 16'h0111, 1'b0, 16'h0BCD, 1'b0);
        measure_latency("latency_after_reset");
        drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
